// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM generator:
//   - default counter / duty width and prescaler width
//   - period shadow value loaded at reset (2499 -> 20 kHz from 50 MHz)
//   - counting mode enum (edge- or centre-aligned)
//   - counting direction enum used by the centre-aligned counter
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int          PWM_CW_DEF         = 16;
    localparam int          PWM_PW_DEF         = 13;
    localparam logic [15:0] PWM_DEFAULT_PERIOD = 16'd2499;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
// Clock-enable generator: emits a one-cycle tick every prescale+1 cycles of
// clkin while enable is high. The counter is held at zero while disabled, so
// the first tick after enable rises comes prescale+1 cycles later.
//
// Ports:
//   clkin     in  : clock, rising edge
//   rst       in  : synchronous active-high reset
//   enable    in  : run the prescaler
//   prescale  in  : [PW-1:0] divide value minus one, sampled live
//   tick      out : combinational clock-enable pulse
// ---------------------------------------------------------------------------
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PW = PWM_PW_DEF
) (
    input  logic          clkin,
    input  logic          rst,
    input  logic          enable,
    input  logic [PW-1:0] prescale,
    output logic          tick
);

    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_cnt_d;

    // Only an exact match ends a prescale interval. If prescale is lowered
    // below the current count, the counter keeps going and wraps through
    // 2^PW before matching again.
    always_comb begin
        tick      = 1'b0;
        pre_cnt_d = pre_cnt_q;
        if (!enable) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q == prescale) begin
            tick      = 1'b1;
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_gen_mc.sv
// ---------------------------------------------------------------------------
// pwm_gen_mc
// Multi-channel PWM generator running entirely on clkin with a prescaler
// clock-enable. Period and per-channel duty are double buffered:
// a load strobe writes staging registers, and the staged values move into
// the shadow registers (which drive the counter and comparators) only at a
// period boundary, or immediately while the generator is disabled.
//
// Optional feature macro: PWM_CENTER_ALIGNED_EN
//   When defined, a 'center' input is added and latched with the period.
//   A shadowed centre mode counts 0..period then back down to 0, giving a
//   2*period tick cycle with outputs symmetric about the peak.
//
// Ports:
//   clkin        in  : clock, rising edge
//   rst          in  : synchronous active-high reset
//   enable       in  : run prescaler and counter; low forces outputs low
//   prescale     in  : [PW-1:0] tick every prescale+1 clkin cycles
//   period       in  : [CW-1:0] counter runs 0..period
//   duty         in  : [CH*CW-1:0] packed duties, channel i at [i*CW +: CW]
//   load         in  : strobe capturing period/duty (and center) into staging
//   center       in  : centre-aligned select (only with the macro)
//   pwm_out      out : [CH-1:0] registered PWM outputs
//   cycle_start  out : registered pulse at each counter wrap
//   load_ack     out : registered pulse when the shadow registers update
// ---------------------------------------------------------------------------
module pwm_gen_mc
    import pwm_pkg::*;
#(
    parameter int            CH             = 4,
    parameter int            CW             = PWM_CW_DEF,
    parameter int            PW             = PWM_PW_DEF,
    parameter logic [CW-1:0] DEFAULT_PERIOD = CW'(PWM_DEFAULT_PERIOD)
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             enable,
    input  logic [PW-1:0]    prescale,
    input  logic [CW-1:0]    period,
    input  logic [CH*CW-1:0] duty,
    input  logic             load,
`ifdef PWM_CENTER_ALIGNED_EN
    input  logic             center,
`endif
    output logic [CH-1:0]    pwm_out,
    output logic             cycle_start,
    output logic             load_ack
);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic tick;

    pwm_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clkin    (clkin),
        .rst      (rst),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]          cnt_q,          cnt_d;
    logic [CW-1:0]          period_sh_q,    period_sh_d;
    logic [CW-1:0]          period_st_q,    period_st_d;
    logic [CH-1:0][CW-1:0]  duty_sh_q,      duty_sh_d;
    logic [CH-1:0][CW-1:0]  duty_st_q,      duty_st_d;
    logic                   load_pending_q, load_pending_d;
    logic [CH-1:0]          pwm_q,          pwm_d;
    logic                   cycle_start_q,  cycle_start_d;
    logic                   load_ack_q,     load_ack_d;
`ifdef PWM_CENTER_ALIGNED_EN
    pwm_mode_e              mode_sh_q,      mode_sh_d;
    pwm_mode_e              mode_st_q,      mode_st_d;
    pwm_dir_e               dir_q,          dir_d;
`endif

    logic boundary;
    logic apply_load;

    // ------------------------------------------------------------------
    // Counter and boundary detection
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        boundary = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        dir_d    = dir_q;
`endif
        if (!enable) begin
            cnt_d = '0;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_d = DIR_UP;
`endif
        end else if (tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
            if (mode_sh_q == PWM_CENTER) begin
                if (dir_q == DIR_DOWN) begin
                    // Reaching zero on the way down closes the cycle; the
                    // zero tick itself belongs to the new cycle, so the
                    // next value is 1 (keeps the cycle at 2*period ticks).
                    if (cnt_q == '0) begin
                        boundary = 1'b1;
                        dir_d    = DIR_UP;
                        cnt_d    = (period_sh_q == '0) ? '0 : CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    if (cnt_q == period_sh_q) begin
                        if (period_sh_q == '0) begin
                            // Degenerate period: every tick wraps.
                            boundary = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            dir_d = DIR_DOWN;
                            cnt_d = cnt_q - CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end else
`endif
            begin
                if (cnt_q == period_sh_q) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Staging / shadow double buffer
    // ------------------------------------------------------------------
    // A disabled generator has no boundaries, so a pending load is applied
    // straight away in that case.
    assign apply_load = load_pending_q && (boundary || !enable);

    always_comb begin
        period_st_d    = period_st_q;
        duty_st_d      = duty_st_q;
        period_sh_d    = period_sh_q;
        duty_sh_d      = duty_sh_q;
        load_pending_d = load_pending_q;
`ifdef PWM_CENTER_ALIGNED_EN
        mode_st_d      = mode_st_q;
        mode_sh_d      = mode_sh_q;
`endif

        // Shadows take the staging contents as they were before this
        // cycle; a load arriving on the boundary cycle is therefore held
        // for the following boundary.
        if (apply_load) begin
            period_sh_d    = period_st_q;
            duty_sh_d      = duty_st_q;
            load_pending_d = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            mode_sh_d      = mode_st_q;
`endif
        end

        if (load) begin
            period_st_d    = period;
            duty_st_d      = duty;
            load_pending_d = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
            mode_st_d      = center ? PWM_CENTER : PWM_EDGE;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Per-channel comparators
    // ------------------------------------------------------------------
    // duty = 0 never matches; duty > period always matches since cnt never
    // exceeds the period.
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        assign pwm_d[gi] = enable && (cnt_q < duty_sh_q[gi]);
    end

    assign cycle_start_d = boundary;
    assign load_ack_d    = apply_load;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt_q          <= '0;
            period_sh_q    <= DEFAULT_PERIOD;
            period_st_q    <= '0;
            duty_sh_q      <= '0;
            duty_st_q      <= '0;
            load_pending_q <= 1'b0;
            pwm_q          <= '0;
            cycle_start_q  <= 1'b0;
            load_ack_q     <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            mode_sh_q      <= PWM_EDGE;
            mode_st_q      <= PWM_EDGE;
            dir_q          <= DIR_UP;
`endif
        end else begin
            cnt_q          <= cnt_d;
            period_sh_q    <= period_sh_d;
            period_st_q    <= period_st_d;
            duty_sh_q      <= duty_sh_d;
            duty_st_q      <= duty_st_d;
            load_pending_q <= load_pending_d;
            pwm_q          <= pwm_d;
            cycle_start_q  <= cycle_start_d;
            load_ack_q     <= load_ack_d;
`ifdef PWM_CENTER_ALIGNED_EN
            mode_sh_q      <= mode_sh_d;
            mode_st_q      <= mode_st_d;
            dir_q          <= dir_d;
`endif
        end
    end

    assign pwm_out     = pwm_q;
    assign cycle_start = cycle_start_q;
    assign load_ack    = load_ack_q;

endmodule
